// File: rtl/adder_wb_requester_if.sv
// Bundle of the Wishbone slave port and the adder core val/rdy port.
// The slave modport is the requester's view; master is the SoC/core side.
interface adder_wb_requester_if #(
    parameter int MSG_W  = 32,
    parameter int RESP_W = 16
);
    // Wishbone slave port
    logic              wbs_stb_i;
    logic              wbs_cyc_i;
    logic              wbs_we_i;
    logic [3:0]        wbs_sel_i;
    logic [31:0]       wbs_dat_i;
    logic [31:0]       wbs_adr_i;
    logic              wbs_ack_o;
    logic [31:0]       wbs_dat_o;

    // Core request/response port
    logic [MSG_W-1:0]  req_msg;
    logic              req_val;
    logic              req_rdy;
    logic [RESP_W-1:0] resp_msg;
    logic              resp_val;
    logic              resp_rdy;

    // Interrupt to the SoC (user_irq[0])
    logic              irq;

    modport slave (
        input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
        output wbs_ack_o, wbs_dat_o,
        output req_msg, req_val,
        input  req_rdy,
        input  resp_msg, resp_val,
        output resp_rdy,
        output irq
    );

    modport master (
        output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
        input  wbs_ack_o, wbs_dat_o,
        input  req_msg, req_val,
        output req_rdy,
        output resp_msg, resp_val,
        input  resp_rdy,
        input  irq
    );
endinterface

// File: rtl/adder_wb_requester.sv
// Wishbone-mapped request engine for the adder core: firmware stages a
// request, launches it with GO, and reads back the result once DONE is set.
// Every output is a flop; core inputs only reach state through registers.
module adder_wb_requester #(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int          MSG_W     = 32,
    parameter int          RESP_W    = 16
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_i,
    adder_wb_requester_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        OFF_REQ_DATA = 2'd0,
        OFF_CTRL     = 2'd1,
        OFF_RESULT   = 2'd2,
        OFF_COUNT    = 2'd3
    } reg_off_e;

    state_e            state_q, state_d;
    logic              req_val_q, resp_rdy_q;
    logic              ack_q;
    logic [31:0]       dat_o_q;
    logic [31:0]       req_data_q;
    logic [MSG_W-1:0]  launch_q;
    logic [RESP_W-1:0] result_q;
    logic [15:0]       count_q;
    logic              done_q, err_q;

    logic              wb_hit, wr_en, rd_en;
    reg_off_e          reg_off;
    logic              go, clr_err, busy, launch, go_err;
    logic              req_fire, resp_fire, result_rd;
    logic [31:0]       rd_word;

    // Bus decode: accept only when no ack is outstanding, so each access
    // takes exactly two cycles and is never double-counted.
    assign wb_hit  = bus.wbs_stb_i & bus.wbs_cyc_i & ~ack_q &
                     (bus.wbs_adr_i[31:4] == BASE_ADDR[31:4]);
    assign wr_en   = wb_hit & bus.wbs_we_i;
    assign rd_en   = wb_hit & ~bus.wbs_we_i;
    assign reg_off = reg_off_e'(bus.wbs_adr_i[3:2]);

    // CTRL bits live in byte lane 0; a write without that lane does nothing.
    assign go      = wr_en & (reg_off == OFF_CTRL) & bus.wbs_sel_i[0] & bus.wbs_dat_i[0];
    assign clr_err = wr_en & (reg_off == OFF_CTRL) & bus.wbs_sel_i[0] & bus.wbs_dat_i[1];

    assign busy      = (state_q != IDLE);
    assign launch    = go & ~busy;
    assign go_err    = go & busy;
    assign req_fire  = (state_q == REQ)  & bus.req_rdy;
    assign resp_fire = (state_q == WAIT) & bus.resp_val;
    assign result_rd = rd_en & (reg_off == OFF_RESULT);

    // Next-state logic for the request FSM.
    always_comb begin
        // NOTE: every variable assigned here gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (launch)    state_d = REQ;
            REQ:     if (req_fire)  state_d = WAIT;
            WAIT:    if (resp_fire) state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    // State register; handshake outputs are registered from the next state
    // so they change together with the state and carry no input paths.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q    <= IDLE;
            req_val_q  <= 1'b0;
            resp_rdy_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the
            // pre-edge value of every other flop, independent of order.
            state_q    <= state_d;
            req_val_q  <= (state_d == REQ);
            resp_rdy_q <= (state_d == WAIT);
        end
    end

    // Read-data mux over the register map.
    always_comb begin
        rd_word = '0;
        unique case (reg_off)
            OFF_REQ_DATA: rd_word = req_data_q;
            OFF_CTRL:     rd_word = {29'd0, err_q, done_q, busy};
            OFF_RESULT:   rd_word = 32'(result_q);
            OFF_COUNT:    rd_word = 32'(count_q);
            default:      rd_word = '0;
        endcase
    end

    // Single-cycle ack with read data registered alongside it.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            ack_q   <= 1'b0;
            dat_o_q <= '0;
        end else begin
            ack_q   <= wb_hit;
            dat_o_q <= rd_en ? rd_word : '0;
        end
    end

    // REQ_DATA staging register with per-byte write enables.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            req_data_q <= '0;
        end else if (wr_en && (reg_off == OFF_REQ_DATA)) begin
            for (int i = 0; i < 4; i++) begin
                if (bus.wbs_sel_i[i]) req_data_q[8*i +: 8] <= bus.wbs_dat_i[8*i +: 8];
            end
        end
    end

    // Launch register: snapshot of REQ_DATA taken at GO, held until next GO.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            launch_q <= '0;
        end else if (launch) begin
            launch_q <= req_data_q[MSG_W-1:0];
        end
    end

    // Completion bookkeeping: result capture, counter, DONE and ERR flags.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            result_q <= '0;
            count_q  <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            if (resp_fire) begin
                result_q <= bus.resp_msg;
                count_q  <= count_q + 16'd1;
            end
            // Completion beats a coincident RESULT read.
            if (resp_fire)      done_q <= 1'b1;
            else if (result_rd) done_q <= 1'b0;
            // A rejected GO beats a coincident CLR_ERR.
            if (go_err)         err_q <= 1'b1;
            else if (clr_err)   err_q <= 1'b0;
        end
    end

    assign bus.wbs_ack_o = ack_q;
    assign bus.wbs_dat_o = dat_o_q;
    assign bus.req_msg   = launch_q;
    assign bus.req_val   = req_val_q;
    assign bus.resp_rdy  = resp_rdy_q;
    assign bus.irq       = done_q;

endmodule
